// File: rtl/hex_display_scan_if.sv
// hex_display_scan_if: groups the data-capture controls and the multiplexed
// seven-segment outputs of hex_display_scan into one bundle.
//   data_hi, data_lo : 8-bit upper/lower display bytes
//   load, hold       : capture strobe and capture freeze
//   blank            : turn all digits off
//   an, seg, dp      : active-low anodes, segments {g..a} and decimal point
//   digit_idx        : digit currently being scanned
//   frame_done       : one-cycle pulse at the end of each 4-digit frame
// The master modport drives the data/control side, and the slave modport is
// the display scanner.
interface hex_display_scan_if;
    logic [7:0] data_hi;
    logic [7:0] data_lo;
    logic       load;
    logic       hold;
    logic       blank;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] digit_idx;
    logic       frame_done;

    modport master (
        output data_hi, data_lo, load, hold, blank,
        input  an, seg, dp, digit_idx, frame_done
    );

    modport slave (
        input  data_hi, data_lo, load, hold, blank,
        output an, seg, dp, digit_idx, frame_done
    );
endinterface

// File: rtl/hex_display_scan.sv
// hex_display_scan: time-multiplexed driver for a 4-digit, common-anode,
// seven-segment display. It shows a 16-bit value as four hex digits, with
// digit 0 rightmost and a decimal point between the two bytes.
//   clk   : system clock, rising edge
//   rst   : synchronous, active-high reset
//   disp  : hex_display_scan_if.slave. Inputs are data_hi/data_lo/load/hold/blank.
//           Outputs are an/seg/dp/digit_idx/frame_done.
// A new value is captured into a pending register on load (unless hold is
// set). It only becomes visible at a frame boundary, so a frame never shows
// a mix of old and new digits.
module hex_display_scan #(
    parameter int PRESCALE = 100000
) (
    input  logic              clk,
    input  logic              rst,
    hex_display_scan_if.slave disp
);

    localparam logic [19:0] CNT_LAST = 20'(PRESCALE - 1);

    logic [19:0] cnt_q, cnt_d;
    logic [1:0]  digit_idx_q, digit_idx_d;
    logic [15:0] pending_q, pending_d;
    logic [15:0] shown_q, shown_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic        frame_done_q, frame_done_d;

    logic        tick;
    logic        frame_end;
    logic [3:0]  nibble;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign tick      = (cnt_q == CNT_LAST);
    assign frame_end = tick && (digit_idx_q == 2'd3);
    assign nibble    = shown_q[{digit_idx_q, 2'b00} +: 4];

    always_comb begin
        cnt_d        = tick ? '0 : cnt_q + 20'd1;
        digit_idx_d  = tick ? digit_idx_q + 2'd1 : digit_idx_q;
        frame_done_d = frame_end;

        // The shown register takes the value that pending holds before this
        // edge, so a load in the same cycle waits one frame longer.
        shown_d   = frame_end ? pending_q : shown_q;
        pending_d = (disp.load && !disp.hold) ? {disp.data_hi, disp.data_lo} : pending_q;

        // Outputs are built from the current index and shown value, so they
        // trail digit_idx by one cycle.
        if (disp.blank) begin
            an_d  = '1;
            seg_d = '1;
            dp_d  = 1'b1;
        end else begin
            an_d  = ~(4'b0001 << digit_idx_q);
            seg_d = hex_to_seg(nibble);
            dp_d  = (digit_idx_q != 2'd2);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            digit_idx_q  <= '0;
            pending_q    <= '0;
            shown_q      <= '0;
            an_q         <= '1;
            seg_q        <= '1;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            digit_idx_q  <= digit_idx_d;
            pending_q    <= pending_d;
            shown_q      <= shown_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign disp.an         = an_q;
    assign disp.seg        = seg_q;
    assign disp.dp         = dp_q;
    assign disp.digit_idx  = digit_idx_q;
    assign disp.frame_done = frame_done_q;

endmodule

// File: doc/hex_display_scan.md
HEX_DISPLAY_SCAN -- requirements
Module: hex_display_scan

Interface
REQ-001 Parameter PRESCALE, default 100000, clk cycles per digit slot; legal range 2..1048576.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 data_hi  input  8  upper display byte (processor instruction/opcode byte).
REQ-005 data_lo  input  8  lower display byte (processor fpga_out).
REQ-006 load  input  1  capture strobe; samples {data_hi,data_lo}.
REQ-007 hold  input  1  freeze; load is ignored while high.
REQ-008 blank  input  1  disables all anodes.
REQ-009 an  output  4  digit enables, active-low, one-hot.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 dp  output  1  decimal point, active-low.
REQ-012 digit_idx  output  2  digit currently scanned.
REQ-013 frame_done  output  1  one-cycle pulse at the end of each 4-digit frame.

Function
REQ-014 Prescaler: 20-bit counter cnt counts 0..PRESCALE-1 and wraps to 0; tick = (cnt==PRESCALE-1).
REQ-015 On tick, digit_idx SHALL increment, wrapping from 3 to 0; digit_idx holds otherwise.
REQ-016 frame_done SHALL be 1 for exactly the cycle after a tick with digit_idx==3; 0 otherwise.
REQ-017 pending (16 bit) SHALL load {data_hi,data_lo} on the cycle after load==1 && hold==0; hold==1 leaves pending unchanged.
REQ-018 shown (16 bit) SHALL copy pending only on a tick with digit_idx==3 (frame boundary), so no frame mixes old and new data.
REQ-019 Load and frame boundary in the same cycle: shown takes the old pending, pending takes the new data, and the new data appears from the frame after next.
REQ-020 Digit n (n=digit_idx) SHALL display nibble shown[4n+3:4n]; digit 0 is rightmost.
REQ-021 an SHALL be registered: idx0->1110, idx1->1101, idx2->1011, idx3->0111; 1111 when blank==1.
REQ-022 seg SHALL be registered hex decode (hex values of the 7-bit code): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-023 seg SHALL be 7F (all off) when blank==1.
REQ-024 dp SHALL be 0 when digit_idx==2 and blank==0 (byte separator); 1 otherwise.
REQ-025 an, seg and dp SHALL lag digit_idx by exactly one clk cycle; blank takes effect on the next edge.
REQ-026 load, hold and blank SHALL have no effect on cnt or digit_idx.

Reset
REQ-027 While rst==1: cnt=0, digit_idx=0, pending=0000, shown=0000, an=1111, seg=7F, dp=1, frame_done=0.
REQ-028 Reset asserted mid-frame SHALL abort the scan and discard any pending capture.
REQ-029 After rst deasserts, the first tick SHALL occur PRESCALE cycles later.
REQ-030 During the first frame after reset, with no load, the display SHALL show 0000 (seg=40 on each digit).

Verification (PRESCALE=4)
REQ-031 Reset, then idle 32 cycles -> an sequence 1110,1101,1011,0111 repeating, each for 4 cycles; seg=40 on every digit; frame_done pulses every 16 cycles.
REQ-032 data_hi=A5, data_lo=3C, one-cycle load mid-frame -> displayed digits unchanged until the next frame boundary; then digits 0..3 show C,3,5,A (seg 46,30,12,08).
REQ-033 hold=1 with load pulse data=FFFF -> pending and display unchanged; release hold and pulse load -> FFFF shown (seg 0E on all digits) after the next boundary.
REQ-034 Load pulse on the same cycle as a frame-boundary tick -> old pending is shown for one full frame, then the new value.
REQ-035 blank=1 mid-scan -> an=1111 and seg=7F on the next edge while digit_idx keeps advancing; blank=0 -> the correct digit resumes on the next edge.
REQ-036 Assert rst for 1 cycle at digit_idx=2 with a load pending -> all outputs at their reset values; display 0000 after recovery.
